// File: rtl/bp_be_stride_detector.sv
// Reference-prediction table that learns constant positive load strides per PC
// and hands one {pc, addr, stride, depth} request at a time to the prefetch generator.
module bp_be_stride_detector #(
    parameter int vaddr_width_p    = 39,
    parameter int entries_p        = 16,
    parameter int tag_width_p      = 10,
    parameter int stride_width_p   = 8,
    parameter int loop_range_p     = 8,
    parameter int conf_bits_p      = 2,
    parameter int conf_thresh_p    = 2,
    parameter int prefetch_depth_p = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      flush_i,
    input  logic                      v_i,
    input  logic [vaddr_width_p-1:0]  pc_i,
    input  logic [vaddr_width_p-1:0]  eff_addr_i,
    output logic                      v_o,
    input  logic                      ready_and_i,
    output logic [vaddr_width_p-1:0]  pc_o,
    output logic [vaddr_width_p-1:0]  eff_addr_o,
    output logic [stride_width_p-1:0] stride_o,
    output logic [loop_range_p-1:0]   loop_counter_o
);

    localparam int idx_w = $clog2(entries_p);
    localparam logic [conf_bits_p-1:0]  conf_one    = conf_bits_p'(1);
    localparam logic [conf_bits_p-1:0]  conf_thresh = conf_bits_p'(conf_thresh_p);
    localparam logic [loop_range_p-1:0] rcnt_one    = loop_range_p'(1);
    localparam logic [loop_range_p-1:0] depth       = loop_range_p'(prefetch_depth_p);

    logic                      valid_q     [entries_p];
    logic [tag_width_p-1:0]    tag_q       [entries_p];
    logic [vaddr_width_p-1:0]  last_addr_q [entries_p];
    logic [stride_width_p-1:0] stride_q    [entries_p];
    logic [conf_bits_p-1:0]    conf_q      [entries_p];
    logic [loop_range_p-1:0]   rcnt_q      [entries_p];

    logic                      valid_d     [entries_p];
    logic [tag_width_p-1:0]    tag_d       [entries_p];
    logic [vaddr_width_p-1:0]  last_addr_d [entries_p];
    logic [stride_width_p-1:0] stride_d    [entries_p];
    logic [conf_bits_p-1:0]    conf_d      [entries_p];
    logic [loop_range_p-1:0]   rcnt_d      [entries_p];

    logic                      v_o_q, v_o_d;
    logic [vaddr_width_p-1:0]  pc_o_q, pc_o_d;
    logic [vaddr_width_p-1:0]  addr_o_q, addr_o_d;
    logic [stride_width_p-1:0] stride_o_q, stride_o_d;

    logic [idx_w-1:0]          idx;
    logic [tag_width_p-1:0]    tag;
    logic                      hit, qual, match, trigger, out_load;
    logic [vaddr_width_p-1:0]  delta;
    logic [conf_bits_p-1:0]    conf_inc;

    always_comb begin
        valid_d     = valid_q;
        tag_d       = tag_q;
        last_addr_d = last_addr_q;
        stride_d    = stride_q;
        conf_d      = conf_q;
        rcnt_d      = rcnt_q;
        v_o_d       = v_o_q;
        pc_o_d      = pc_o_q;
        addr_o_d    = addr_o_q;
        stride_o_d  = stride_o_q;

        idx      = pc_i[2 +: idx_w];
        tag      = pc_i[2+idx_w +: tag_width_p];
        hit      = valid_q[idx] && (tag_q[idx] == tag);
        delta    = eff_addr_i - last_addr_q[idx];
        // Wrapped negative deltas land in the upper range, so they fail the high-bits test.
        qual     = (delta != '0) && (delta[vaddr_width_p-1:stride_width_p] == '0);
        match    = hit && qual && (delta[stride_width_p-1:0] == stride_q[idx]);
        conf_inc = (conf_q[idx] == '1) ? conf_q[idx] : conf_q[idx] + conf_one;
        trigger  = v_i && !flush_i && match && (conf_inc >= conf_thresh) && (rcnt_q[idx] <= rcnt_one);
        out_load = trigger && (!v_o_q || ready_and_i);

        if (flush_i) begin
            for (int unsigned i = 0; i < entries_p; i++) begin
                valid_d[i] = 1'b0;
            end
            v_o_d = 1'b0;
        end else begin
            if (v_i) begin
                if (!hit) begin
                    valid_d[idx]     = 1'b1;
                    tag_d[idx]       = tag;
                    last_addr_d[idx] = eff_addr_i;
                    stride_d[idx]    = '0;
                    conf_d[idx]      = '0;
                    rcnt_d[idx]      = '0;
                end else begin
                    last_addr_d[idx] = eff_addr_i;
                    if (match) begin
                        conf_d[idx] = conf_inc;
                        if (trigger) begin
                            rcnt_d[idx] = out_load ? depth : '0;
                        end else if (rcnt_q[idx] != '0) begin
                            rcnt_d[idx] = rcnt_q[idx] - rcnt_one;
                        end
                    end else begin
                        stride_d[idx] = qual ? delta[stride_width_p-1:0] : '0;
                        conf_d[idx]   = '0;
                        rcnt_d[idx]   = '0;
                    end
                end
            end

            if (out_load) begin
                v_o_d      = 1'b1;
                pc_o_d     = pc_i;
                addr_o_d   = eff_addr_i;
                stride_o_d = stride_q[idx];
            end else if (ready_and_i) begin
                v_o_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < entries_p; i++) begin
                valid_q[i]     <= 1'b0;
                tag_q[i]       <= '0;
                last_addr_q[i] <= '0;
                stride_q[i]    <= '0;
                conf_q[i]      <= '0;
                rcnt_q[i]      <= '0;
            end
            v_o_q      <= 1'b0;
            pc_o_q     <= '0;
            addr_o_q   <= '0;
            stride_o_q <= '0;
        end else begin
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            last_addr_q <= last_addr_d;
            stride_q    <= stride_d;
            conf_q      <= conf_d;
            rcnt_q      <= rcnt_d;
            v_o_q       <= v_o_d;
            pc_o_q      <= pc_o_d;
            addr_o_q    <= addr_o_d;
            stride_o_q  <= stride_o_d;
        end
    end

    assign v_o            = v_o_q;
    assign pc_o           = pc_o_q;
    assign eff_addr_o     = addr_o_q;
    assign stride_o       = stride_o_q;
    assign loop_counter_o = depth;

endmodule

// File: tb/tb_bp_be_stride_detector.sv
// Directed bench for bp_be_stride_detector: training, reissue spacing, rejected
// strides, backpressure, flush and asynchronous reset.
module tb_bp_be_stride_detector;

    localparam int VW = 39;
    localparam logic [VW-1:0] PC_A = 39'h0080000100;
    localparam logic [VW-1:0] PC_B = 39'h0080000204;
    localparam logic [VW-1:0] PC_C = 39'h0080000308;
    localparam logic [VW-1:0] PC_D = 39'h008000040C;
    localparam logic [VW-1:0] PC_E = 39'h0080000510;

    logic          clk = 1'b0;
    logic          reset_i, flush_i, v_i, ready_and_i, v_o;
    logic [VW-1:0] pc_i, eff_addr_i, pc_o, eff_addr_o;
    logic [7:0]    stride_o, loop_counter_o;

    int checks = 0;
    int errors = 0;

    bp_be_stride_detector #(
        .vaddr_width_p(VW), .entries_p(16), .tag_width_p(10), .stride_width_p(8),
        .loop_range_p(8), .conf_bits_p(2), .conf_thresh_p(2), .prefetch_depth_p(4)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i), .v_i(v_i),
        .pc_i(pc_i), .eff_addr_i(eff_addr_i), .v_o(v_o), .ready_and_i(ready_and_i),
        .pc_o(pc_o), .eff_addr_o(eff_addr_o), .stride_o(stride_o),
        .loop_counter_o(loop_counter_o)
    );

    always #5 clk = ~clk;

    // Inputs change at negedge; after return, outputs reflect the captured load.
    task automatic load(input logic [VW-1:0] pc, input logic [VW-1:0] addr);
        pc_i = pc; eff_addr_i = addr; v_i = 1'b1;
        @(negedge clk);
        v_i = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o got %b want 0", v_o); end
        checks++; if (pc_o !== '0) begin errors++; $display("FAIL reset_pc_o got %h want 0", pc_o); end
        checks++; if (eff_addr_o !== '0) begin errors++; $display("FAIL reset_addr_o got %h want 0", eff_addr_o); end
        checks++; if (stride_o !== 8'd0) begin errors++; $display("FAIL reset_stride_o got %0d want 0", stride_o); end
        checks++; if (loop_counter_o !== 8'd4) begin errors++; $display("FAIL reset_loop_counter got %0d want 4", loop_counter_o); end
    endtask

    // Load1 allocates, load2 learns stride 8, load3 conf=1, load4 conf=2 -> issue.
    task automatic test_train(input string name);
        logic exp_v;
        for (int i = 0; i < 4; i++) begin
            load(PC_A, 39'h1000 + VW'(i * 8));
            exp_v = (i == 3);
            checks++;
            if (v_o !== exp_v) begin errors++; $display("FAIL %s_v_o load%0d got %b want %b", name, i + 1, v_o, exp_v); end
        end
        checks++; if (pc_o !== PC_A) begin errors++; $display("FAIL %s_pc_o got %h want %h", name, pc_o, PC_A); end
        checks++; if (eff_addr_o !== 39'h1018) begin errors++; $display("FAIL %s_addr_o got %h want 1018", name, eff_addr_o); end
        checks++; if (stride_o !== 8'd8) begin errors++; $display("FAIL %s_stride_o got %0d want 8", name, stride_o); end
        checks++; if (loop_counter_o !== 8'd4) begin errors++; $display("FAIL %s_loop_counter got %0d want 4", name, loop_counter_o); end
    endtask

    // After an issue rcnt=4; three hits take it to 1, the fourth reissues.
    task automatic test_reissue();
        logic exp_v;
        for (int i = 0; i < 5; i++) begin
            load(PC_A, 39'h1020 + VW'(i * 8));
            exp_v = (i == 3);
            checks++;
            if (v_o !== exp_v) begin errors++; $display("FAIL reissue_v_o addr %h got %b want %b", eff_addr_i, v_o, exp_v); end
            if (i == 3) begin
                checks++;
                if (eff_addr_o !== 39'h1038) begin errors++; $display("FAIL reissue_addr_o got %h want 1038", eff_addr_o); end
            end
        end
    endtask

    task automatic test_nonpositive();
        logic [VW-1:0] addrs [7];
        addrs = '{39'h2000, 39'h1FF8, 39'h1FF0, 39'h1FE8, 39'h0, 39'h400, 39'h800};
        for (int i = 0; i < 7; i++) begin
            load(PC_B, addrs[i]);
            checks++;
            if (v_o !== 1'b0) begin errors++; $display("FAIL nonpos_v_o addr %h got %b want 0", addrs[i], v_o); end
        end
    endtask

    task automatic test_backpressure();
        ready_and_i = 1'b0;
        for (int i = 0; i < 4; i++) load(PC_C, 39'h3000 + VW'(i * 4));
        checks++; if (v_o !== 1'b1) begin errors++; $display("FAIL bp_first_v_o got %b want 1", v_o); end
        checks++; if (stride_o !== 8'd4) begin errors++; $display("FAIL bp_first_stride got %0d want 4", stride_o); end
        for (int i = 0; i < 5; i++) begin
            load(PC_D, 39'h5000 + VW'(i * 16));
            checks++;
            if (v_o !== 1'b1 || eff_addr_o !== 39'h300C || pc_o !== PC_C) begin
                errors++;
                $display("FAIL bp_hold load%0d got v=%b addr=%h pc=%h want v=1 addr=300c pc=%h", i, v_o, eff_addr_o, pc_o, PC_C);
            end
        end
        ready_and_i = 1'b1;
        load(PC_D, 39'h5050);
        checks++; if (v_o !== 1'b1) begin errors++; $display("FAIL bp_retry_v_o got %b want 1", v_o); end
        checks++; if (eff_addr_o !== 39'h5050) begin errors++; $display("FAIL bp_retry_addr got %h want 5050", eff_addr_o); end
        checks++; if (stride_o !== 8'd16) begin errors++; $display("FAIL bp_retry_stride got %0d want 16", stride_o); end
        checks++; if (pc_o !== PC_D) begin errors++; $display("FAIL bp_retry_pc got %h want %h", pc_o, PC_D); end
        @(negedge clk);
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL bp_drain_v_o got %b want 0", v_o); end
    endtask

    task automatic test_flush();
        logic exp_v;
        for (int i = 0; i < 4; i++) load(PC_E, 39'h6000 + VW'(i * 8));
        checks++; if (v_o !== 1'b1) begin errors++; $display("FAIL flush_pretrain_v_o got %b want 1", v_o); end
        ready_and_i = 1'b0;
        load(PC_E, 39'h6020);
        flush_i = 1'b1;
        load(PC_E, 39'h6028);
        flush_i = 1'b0;
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL flush_v_o got %b want 0", v_o); end
        ready_and_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load(PC_E, 39'h6030 + VW'(i * 8));
            exp_v = (i == 3);
            checks++;
            if (v_o !== exp_v) begin errors++; $display("FAIL flush_retrain_v_o load%0d got %b want %b", i + 1, v_o, exp_v); end
        end
        checks++; if (eff_addr_o !== 39'h6048) begin errors++; $display("FAIL flush_retrain_addr got %h want 6048", eff_addr_o); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) load(PC_A, 39'h9000 + VW'(i * 8));
        ready_and_i = 1'b0;
        checks++; if (v_o !== 1'b1) begin errors++; $display("FAIL arst_pre_v_o got %b want 1", v_o); end
        #2 reset_i = 1'b1;
        #1;
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL arst_v_o got %b want 0", v_o); end
        checks++; if (stride_o !== 8'd0 || eff_addr_o !== '0) begin errors++; $display("FAIL arst_payload got stride=%0d addr=%h want 0", stride_o, eff_addr_o); end
        @(negedge clk);
        reset_i = 1'b0;
        ready_and_i = 1'b1;
        test_train("post_reset");
    endtask

    initial begin
        reset_i = 1'b1; flush_i = 1'b0; v_i = 1'b0; ready_and_i = 1'b1;
        pc_i = '0; eff_addr_i = '0;
        #1;
        test_reset();
        @(negedge clk);
        reset_i = 1'b0;
        test_train("train");
        test_reissue();
        test_nonpositive();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
